// File: rtl/conv_pkg.sv
// Types shared by the window buffer and the convolution stage that consumes its windows.
package conv_pkg;
  localparam int PIXEL_W   = 48;
  localparam int DEFAULT_K = 3;

  typedef logic signed [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [DEFAULT_K-1:0][DEFAULT_K-1:0] window_t;

  // Counter width for a dimension of n entries; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out streaming bundle between a pixel source, the window buffer and its consumer.
interface conv_window_buffer_if #(
  parameter int KERNEL_SIZE = 3
);
  import conv_pkg::*;

  pixel_t pixel_in;
  logic   in_valid;
  logic   in_sof;
  logic   in_ready;
  pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] window_out;
  logic   out_valid;
  logic   out_last;
  logic   out_ready;

  modport master (
    output pixel_in, in_valid, in_sof, out_ready,
    input  in_ready, window_out, out_valid, out_last
  );

  modport slave (
    input  pixel_in, in_valid, in_sof, out_ready,
    output in_ready, window_out, out_valid, out_last
  );
endinterface

// File: rtl/conv_line_delay.sv
// One image line of delay: the entry at i_addr is read out and replaced by i_din in the same accept.
module conv_line_delay
  import conv_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = PIXEL_W
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [cnt_w(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]        i_din,
  output logic [WIDTH-1:0]        o_dout
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: no reset on the storage array, so it maps onto RAM; every entry is
  // rewritten by a frame's upper rows before a window ever reads it.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_addr] <= i_din;
  end

  // Read returns the previous line's pixel; the write takes effect at the edge.
  assign o_dout = r_mem[i_addr];
endmodule

// File: rtl/conv_window_buffer.sv
// Streams raster pixels into KERNEL_SIZE-1 line delays and a KxK shift window, emitting valid-mode windows.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_window_buffer_if.slave  bus
);
  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_SIZE - 1);

  logic [COL_W-1:0] r_col, w_col, w_col_next;
  logic [ROW_W-1:0] r_row, w_row, w_row_next;
  logic             r_out_valid, r_out_last;
  logic             w_in_ready, w_accept, w_form, w_frame_end;
  pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] r_window;
  pixel_t           w_new_col [KERNEL_SIZE];

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_col      = r_col;
    w_row      = r_row;
    w_col_next = r_col;
    w_row_next = r_row;
    // A start-of-frame pixel is (0,0) whatever the counters say.
    if (bus.in_sof) begin
      w_col = '0;
      w_row = '0;
    end
    if (w_col == COL_LAST) begin
      w_col_next = '0;
      w_row_next = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
    end else begin
      w_col_next = w_col + 1'b1;
      w_row_next = w_row;
    end
  end

  assign w_form      = (w_col >= COL_FIRST) && (w_row >= ROW_FIRST);
  assign w_frame_end = (w_col == COL_LAST) && (w_row == ROW_LAST);

  // Delay i holds the line i+1 rows above the incoming pixel.
  for (genvar i = 0; i < KERNEL_SIZE - 1; i++) begin : g_delay
    pixel_t w_din, w_dout;
    if (i == 0) begin : g_head
      assign w_din = bus.pixel_in;
    end else begin : g_chain
      assign w_din = g_delay[i-1].w_dout;
    end
    conv_line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_line (
      .clk    (clk),
      .i_wr_en(w_accept),
      .i_addr (w_col),
      .i_din  (w_din),
      .o_dout (w_dout)
    );
  end

  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_col
    if (r == KERNEL_SIZE - 1) begin : g_newest
      assign w_new_col[r] = bus.pixel_in;
    end else begin : g_older
      assign w_new_col[r] = g_delay[KERNEL_SIZE-2-r].w_dout;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_window    <= '0;
    end else if (w_accept) begin
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_out_valid <= w_form;
      r_out_last  <= w_form && w_frame_end;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) r_window[r][c] <= r_window[r][c+1];
        r_window[r][KERNEL_SIZE-1] <= w_new_col[r];
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.window_out = r_window;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer on a 4x4 frame with a 3x3 kernel, pixel value row*16+col.
module tb_conv_window_buffer;
  import conv_pkg::*;

  localparam int K = 3;
  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    window_t win;
    logic    last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_window_buffer_if #(.KERNEL_SIZE(K)) bus ();

  conv_window_buffer #(.KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   win_cnt = 0;
  int   last_cnt = 0;

  function automatic window_t make_win(input int r, input int c);
    window_t w;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[i][j] = pixel_t'((r - K + 1 + i) * 16 + (c - K + 1 + j));
    return w;
  endfunction

  // Every window handed to the consumer is checked against the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      win_cnt++;
      if (bus.out_last === 1'b1) last_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_window: got window %h, required none", bus.window_out);
      end else begin
        mon_e = sb.pop_front();
        if (bus.window_out !== mon_e.win) begin
          bad++;
          $display("FAIL window_data: got %h required %h", bus.window_out, mon_e.win);
        end
        total++;
        if (bus.out_last !== mon_e.last) begin
          bad++;
          $display("FAIL window_last: got %b required %b", bus.out_last, mon_e.last);
        end
      end
    end
  end

  task automatic send(input int val, input int r, input int c, input bit sof);
    int budget = 0;
    bus.pixel_in = pixel_t'(val);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && budget <= 200) begin
      budget++;
      @(negedge clk);
    end
    if (budget > 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: pixel %0h not accepted in 200 cycles, required accept", val);
    end else if (r >= K - 1 && c >= K - 1) begin
      sb.push_back('{make_win(r, c), (r == H - 1 && c == W - 1)});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit gappy, input bit sof_first);
    int n;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r * 16 + c, r, c, sof_first && r == 0 && c == 0);
        if (gappy) begin
          n = $urandom_range(0, 2);
          repeat (n) @(posedge clk);
          if (n > 0) #1;
        end
      end
    end
  endtask

  task automatic drain_and_check(input string name, input int exp_wins, input int exp_lasts);
    repeat (4) @(negedge clk);
    total++;
    if (win_cnt !== exp_wins) begin
      bad++;
      $display("FAIL %s_count: got %0d windows, required %0d", name, win_cnt, exp_wins);
    end
    total++;
    if (last_cnt !== exp_lasts) begin
      bad++;
      $display("FAIL %s_last_count: got %0d, required %0d", name, last_cnt, exp_lasts);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: got %0d windows never emitted, required 0", name, sb.size());
    end
    sb.delete();
    win_cnt  = 0;
    last_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.pixel_in  = '0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
    end
    total++;
    if (bus.out_last !== 1'b0) begin
      bad++; $display("FAIL reset_out_last: got %b required 0", bus.out_last);
    end
    total++;
    if (bus.window_out !== '0) begin
      bad++; $display("FAIL reset_window: got %h required 0", bus.window_out);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_window();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r * 16 + c, r, c, r == 0 && c == 0);
        if (r == 2 && c == 1) begin
          total++;
          if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL early_window: got out_valid %b after 0x21, required 0", bus.out_valid);
          end
        end
        if (r == 2 && c == 2) begin
          total++;
          if (bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL first_window_valid: got %b one cycle after 0x22, required 1", bus.out_valid);
          end
          total++;
          if (bus.window_out !== make_win(2, 2)) begin
            bad++; $display("FAIL first_window_data: got %h required %h", bus.window_out, make_win(2, 2));
          end
        end
      end
    end
    drain_and_check("frame", 4, 1);
  endtask

  task automatic test_backpressure();
    for (int idx = 0; idx <= 10; idx++) send((idx / W) * 16 + idx % W, idx / W, idx % W, idx == 0);
    bus.out_ready = 1'b0;
    fork
      begin
        for (int idx = 11; idx < W * H; idx++) send((idx / W) * 16 + idx % W, idx / W, idx % W, 1'b0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          total++;
          if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready);
          end
          total++;
          if (bus.out_valid !== 1'b1 || bus.window_out !== make_win(2, 2)) begin
            bad++; $display("FAIL bp_hold: got valid %b window %h, required valid 1 window %h",
                            bus.out_valid, bus.window_out, make_win(2, 2));
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain_and_check("backpressure", 4, 1);
  endtask

  task automatic test_gappy();
    send_frame(1'b1, 1'b1);
    drain_and_check("gappy", 4, 1);
  endtask

  task automatic test_sof_resync();
    for (int i = 0; i < 5; i++) send(32'h0F0F_0000 + i, 0, 0, 1'b0);
    send_frame(1'b0, 1'b1);
    drain_and_check("sof_resync", 4, 1);
  endtask

  task automatic test_reset_mid_frame();
    for (int idx = 0; idx <= 9; idx++) send((idx / W) * 16 + idx % W, idx / W, idx % W, idx == 0);
    reset = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_valid: got %b required 0", bus.out_valid);
    end
    total++;
    if (bus.window_out !== '0) begin
      bad++; $display("FAIL midreset_window: got %h required 0", bus.window_out);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_in_ready: got %b required 1", bus.in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // No in_sof: the reset alone must restart the raster at (0,0).
    send_frame(1'b0, 1'b0);
    drain_and_check("after_reset", 4, 1);
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 1'b1);
    send_frame(1'b0, 1'b1);
    drain_and_check("two_frames", 8, 2);
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_backpressure();
    test_gappy();
    test_sof_resync();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
